// File: rtl/riscv_pkg.sv
// Shared RV32 front-end definitions: fetch FSM states, the canonical NOP and
// the word-alignment helper used for the PC and redirect targets.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_avm.sv
// Instruction fetch over an Avalon-MM read master: one outstanding read, an
// instruction register with valid/ready hand-off, and PC redirect with stale-read drop.
module instr_fetch_avm #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [31:0] AVM_ADDRESS,
  output logic        AVM_READ,
  input  logic        AVM_WAITREQUEST,
  input  logic [31:0] AVM_READDATA,
  input  logic        AVM_READDATAVALID,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic [31:0] INSTR_OUT,
  output logic [31:0] PC_OUT,
  output logic        INSTR_VALID,
  input  logic        INSTR_READY,
  output logic        MISALIGN_ERR
);

  import riscv_pkg::XLEN;
  import riscv_pkg::fetch_state_t;
  import riscv_pkg::IDLE;
  import riscv_pkg::REQ;
  import riscv_pkg::WAIT;
  import riscv_pkg::HOLD;
  import riscv_pkg::word_align;

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] target;
  logic            drop;

  assign pc_next  = pc + 32'd4;
  assign target   = word_align(REDIRECT_PC);
  assign AVM_READ = (state == REQ);

  // AVM_ADDRESS is its own register so a redirect during a stalled request
  // can move the PC without changing the address the slave is looking at.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      drop         <= 1'b0;
      AVM_ADDRESS  <= RESET_PC;
      INSTR_OUT    <= NOP_INSTR;
      PC_OUT       <= RESET_PC;
      INSTR_VALID  <= 1'b0;
      MISALIGN_ERR <= 1'b0;
    end else begin
      MISALIGN_ERR <= REDIRECT && (REDIRECT_PC[1:0] != 2'b00);
      if (REDIRECT) begin
        pc <= target;
        case (state)
          IDLE, HOLD: begin
            INSTR_VALID <= 1'b0;
            INSTR_OUT   <= NOP_INSTR;
            AVM_ADDRESS <= target;
            state       <= REQ;
          end
          REQ: begin
            drop <= 1'b1;
            if (!AVM_WAITREQUEST) state <= WAIT;
          end
          WAIT: begin
            if (AVM_READDATAVALID) begin
              drop        <= 1'b0;
              AVM_ADDRESS <= target;
              state       <= REQ;
            end else begin
              drop <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else begin
        case (state)
          IDLE: begin
            AVM_ADDRESS <= pc;
            state       <= REQ;
          end
          REQ: begin
            if (!AVM_WAITREQUEST) state <= WAIT;
          end
          WAIT: begin
            if (AVM_READDATAVALID) begin
              if (drop) begin
                drop        <= 1'b0;
                AVM_ADDRESS <= pc;
                state       <= REQ;
              end else begin
                INSTR_OUT   <= AVM_READDATA;
                PC_OUT      <= pc;
                INSTR_VALID <= 1'b1;
                state       <= HOLD;
              end
            end
          end
          HOLD: begin
            if (INSTR_READY) begin
              pc          <= pc_next;
              AVM_ADDRESS <= pc_next;
              INSTR_VALID <= 1'b0;
              INSTR_OUT   <= NOP_INSTR;
              state       <= REQ;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_avm.sv
// Directed bench for instr_fetch_avm: an Avalon slave model with programmable
// stall/latency, a scoreboard of expected (instr, pc) words and a handshake monitor.
module tb_instr_fetch_avm;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] AVM_ADDRESS;
  logic        AVM_READ;
  logic        AVM_WAITREQUEST;
  logic [31:0] AVM_READDATA;
  logic        AVM_READDATAVALID;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic [31:0] INSTR_OUT;
  logic [31:0] PC_OUT;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic        MISALIGN_ERR;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          stall_cnt = 0;
  int          lat = 1;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;

  instr_fetch_avm #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .CLK              (CLK),
    .RST              (RST),
    .AVM_ADDRESS      (AVM_ADDRESS),
    .AVM_READ         (AVM_READ),
    .AVM_WAITREQUEST  (AVM_WAITREQUEST),
    .AVM_READDATA     (AVM_READDATA),
    .AVM_READDATAVALID(AVM_READDATAVALID),
    .REDIRECT         (REDIRECT),
    .REDIRECT_PC      (REDIRECT_PC),
    .INSTR_OUT        (INSTR_OUT),
    .PC_OUT           (PC_OUT),
    .INSTR_VALID      (INSTR_VALID),
    .INSTR_READY      (INSTR_READY),
    .MISALIGN_ERR     (MISALIGN_ERR)
  );

  always #5 CLK = ~CLK;

  // Slave memory image: address 0 holds addi x1,x0,5; others {addr[23:0], 8'h13}
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[23:0], 8'h13};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!INSTR_VALID && n < 20) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (!INSTR_VALID) begin
      errors++;
      $display("FAIL %s timeout valid=%b required=1", name, INSTR_VALID);
    end
  endtask

  task automatic consume();
    INSTR_READY = 1'b1;
    @(negedge CLK);
    INSTR_READY = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    exp_q.push_back(e);
  endtask

  // Avalon slave: acts 1ns after the falling edge so it sees this edge's stimulus
  initial begin
    AVM_WAITREQUEST   = 1'b0;
    AVM_READDATAVALID = 1'b0;
    AVM_READDATA      = '0;
    forever begin
      @(negedge CLK);
      #1;
      AVM_READDATAVALID = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          AVM_READDATAVALID = 1'b1;
          AVM_READDATA      = mem_word(pend_addr);
        end
      end
      AVM_WAITREQUEST = (stall_cnt > 0);
      if (stall_cnt > 0) stall_cnt--;
      if (AVM_READ && !AVM_WAITREQUEST) begin
        pend_cnt  = lat;
        pend_addr = AVM_ADDRESS;
      end
    end
  end

  // Monitor: every accepted word must match the head of the scoreboard
  initial begin
    forever begin : mon
      exp_t e;
      @(negedge CLK);
      #2;
      if (!RST && INSTR_VALID && INSTR_READY) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word_unexpected actual instr=%h pc=%h required=none", INSTR_OUT, PC_OUT);
        end else begin
          e = exp_q.pop_front();
          check("word_instr", INSTR_OUT, e.instr);
          check("word_pc", PC_OUT, e.pc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b1;
    REDIRECT = 1'b0;
    REDIRECT_PC = '0;
    INSTR_READY = 1'b0;
    repeat (3) @(negedge CLK);

    check("rst_read", AVM_READ, 0);
    check("rst_addr", AVM_ADDRESS, 32'h0);
    check("rst_valid", INSTR_VALID, 0);
    check("rst_instr", INSTR_OUT, NOP);
    check("rst_pc_out", PC_OUT, 32'h0);
    check("rst_misalign", MISALIGN_ERR, 0);

    // 1: zero-wait fetch from RESET_PC
    RST = 1'b0;
    @(negedge CLK);
    check("t1_req_read", AVM_READ, 1);
    check("t1_req_addr", AVM_ADDRESS, 32'h0);
    check("t1_req_valid", INSTR_VALID, 0);
    @(negedge CLK);
    check("t1_wait_read", AVM_READ, 0);
    check("t1_wait_valid", INSTR_VALID, 0);
    @(negedge CLK);
    check("t1_hold_valid", INSTR_VALID, 1);
    check("t1_hold_instr", INSTR_OUT, 32'h0050_0093);
    check("t1_hold_pc", PC_OUT, 32'h0);

    // 2: downstream back-pressure
    repeat (5) begin
      @(negedge CLK);
      check("t2_stable_instr", INSTR_OUT, 32'h0050_0093);
      check("t2_stable_read", AVM_READ, 0);
      check("t2_stable_valid", INSTR_VALID, 1);
    end
    push_exp(32'h0050_0093, 32'h0);
    consume();
    check("t2_next_addr", AVM_ADDRESS, 32'h4);
    check("t2_next_read", AVM_READ, 1);
    push_exp(32'h0000_0413, 32'h4);
    wait_valid("t2_valid");

    // 3: slave stall holds the request
    stall_cnt = 4;
    consume();
    repeat (3) begin
      check("t3_stall_read", AVM_READ, 1);
      check("t3_stall_addr", AVM_ADDRESS, 32'h8);
      check("t3_stall_valid", INSTR_VALID, 0);
      @(negedge CLK);
    end
    push_exp(32'h0000_0813, 32'h8);
    wait_valid("t3_valid");

    // 4: redirect while a read is outstanding drops the returning word
    lat = 2;
    consume();
    check("t4_req_addr", AVM_ADDRESS, 32'hC);
    @(negedge CLK);
    check("t4_wait_read", AVM_READ, 0);
    REDIRECT = 1'b1;
    REDIRECT_PC = 32'h0000_0100;
    @(negedge CLK);
    REDIRECT = 1'b0;
    check("t4_drop_valid", INSTR_VALID, 0);
    @(negedge CLK);
    lat = 1;
    check("t4_after_valid", INSTR_VALID, 0);
    check("t4_after_read", AVM_READ, 1);
    check("t4_after_addr", AVM_ADDRESS, 32'h100);
    push_exp(32'h0001_0013, 32'h100);
    wait_valid("t4_valid");
    consume();

    // 5: misaligned redirect from HOLD, then PC wrap
    push_exp(32'h0001_0413, 32'h104);
    wait_valid("t5_valid_104");
    consume();
    wait_valid("t5_valid_108");
    REDIRECT = 1'b1;
    REDIRECT_PC = 32'h0000_0106;
    @(negedge CLK);
    REDIRECT = 1'b0;
    check("t5_misalign_hi", MISALIGN_ERR, 1);
    check("t5_flush_valid", INSTR_VALID, 0);
    check("t5_flush_instr", INSTR_OUT, NOP);
    check("t5_redir_read", AVM_READ, 1);
    check("t5_redir_addr", AVM_ADDRESS, 32'h104);
    @(negedge CLK);
    check("t5_misalign_lo", MISALIGN_ERR, 0);
    push_exp(32'h0001_0413, 32'h104);
    wait_valid("t5_valid_refetch");
    consume();
    wait_valid("t5_valid_108b");
    REDIRECT = 1'b1;
    REDIRECT_PC = 32'hFFFF_FFFC;
    @(negedge CLK);
    REDIRECT = 1'b0;
    check("t5_aligned_misalign", MISALIGN_ERR, 0);
    check("t5_top_addr", AVM_ADDRESS, 32'hFFFF_FFFC);
    push_exp(32'hFFFF_FC13, 32'hFFFF_FFFC);
    wait_valid("t5_valid_top");
    consume();
    check("t5_wrap_addr", AVM_ADDRESS, 32'h0);
    check("t5_wrap_read", AVM_READ, 1);
    push_exp(32'h0050_0093, 32'h0);
    wait_valid("t5_valid_wrap");

    // 6: reset during WAIT, stale READDATAVALID afterwards
    lat = 2;
    consume();
    check("t6_req_addr", AVM_ADDRESS, 32'h4);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    lat = 1;
    check("t6_rst_read", AVM_READ, 0);
    check("t6_rst_addr", AVM_ADDRESS, 32'h0);
    check("t6_rst_valid", INSTR_VALID, 0);
    check("t6_rst_instr", INSTR_OUT, NOP);
    check("t6_rst_pc_out", PC_OUT, 32'h0);
    check("t6_rst_misalign", MISALIGN_ERR, 0);
    @(negedge CLK);
    check("t6_restart_read", AVM_READ, 1);
    check("t6_restart_addr", AVM_ADDRESS, 32'h0);
    check("t6_restart_valid", INSTR_VALID, 0);
    push_exp(32'h0050_0093, 32'h0);
    wait_valid("t6_valid");
    consume();

    repeat (3) @(negedge CLK);
    check("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
